// File: rtl/mem_access_unit_if.sv
// Request/response and memory-bus signals of the load/store front-end.
// slave: the access unit itself; master: controller plus memory side.
interface mem_access_unit_if #(parameter int ADDR_W = 32);
    logic              req;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_sext;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [31:0]       mem_wd;
    logic [31:0]       mem_rd;

    modport slave (
        input  req, req_we, req_size, req_sext, req_addr, req_wdata, mem_rd,
        output busy, done, err, rdata, mem_we, mem_a, mem_wd
    );

    modport master (
        output req, req_we, req_size, req_sext, req_addr, req_wdata, mem_rd,
        input  busy, done, err, rdata, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store front-end for a word-only memory; sub-word stores use read-modify-write.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word requests with err instead of ignoring low address bits.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input logic              clk,
    input logic              reset,
    mem_access_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              sext_q;
    logic [31:0]       merged_q;
    logic [31:0]       rdata_q;
    logic              accept;
    logic              trap;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [31:0]       load_val;
    logic [31:0]       merge_val;

    assign accept = (state == IDLE) && bus.req;

`ifdef MEM_MISALIGN_TRAP_EN
    logic err_q;

    assign trap = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                  (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else if (accept)
            err_q <= trap;
    end

    assign bus.err = (state == RESP) && err_q;
`else
    assign trap    = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (trap)
                        state_next = RESP;
                    else if (bus.req_we && bus.req_size[1])
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD:      state_next = we_q ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lane selection and extension for loads, lane replacement for sub-word stores.
    always_comb begin
        lane_byte = bus.mem_rd[{addr_q[1:0], 3'b000} +: 8];
        lane_half = addr_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
        case (size_q)
            2'b00:   load_val = {{24{sext_q & lane_byte[7]}}, lane_byte};
            2'b01:   load_val = {{16{sext_q & lane_half[15]}}, lane_half};
            default: load_val = bus.mem_rd;
        endcase
        merge_val = bus.mem_rd;
        if (size_q == 2'b00)
            merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            we_q     <= 1'b0;
            sext_q   <= 1'b0;
            merged_q <= '0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                size_q  <= bus.req_size;
                we_q    <= bus.req_we;
                sext_q  <= bus.req_sext;
            end
            if (state == RD) begin
                if (we_q)
                    merged_q <= merge_val;
                else
                    rdata_q <= load_val;
            end
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == RESP);
    assign bus.mem_we = (state == WR);
    assign bus.mem_a  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_wd = size_q[1] ? wdata_q : merged_q;
    assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a small word memory model.
// Honours MEM_MISALIGN_TRAP_EN to select the expected misaligned behaviour.
module tb_mem_access_unit;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [31:0] mem [0:63];
    logic        tbWe;
    logic [5:0]  tbIdx;
    logic [31:0] tbData;

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: combinational read, write on the rising edge.
    assign bus.mem_rd = mem[bus.mem_a[7:2]];

    always @(posedge clk) begin
        if (bus.mem_we)
            mem[bus.mem_a[7:2]] <= bus.mem_wd;
        else if (tbWe)
            mem[tbIdx] <= tbData;
    end

    task automatic loadWord(input logic [5:0] idx, input logic [31:0] data);
        tbIdx  = idx;
        tbData = data;
        tbWe   = 1'b1;
        @(posedge clk);
        #1;
        tbWe   = 1'b0;
    endtask

    // Issues one request and follows it to done; called just after a rising edge.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sext,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output int lat, output int weCnt, output logic [31:0] lastWd,
                                 output logic [31:0] lastA, output logic sawErr);
        bus.req       = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_sext  = sext;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        lat     = 1;
        weCnt   = 0;
        lastWd  = '0;
        lastA   = '0;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.mem_we === 1'b1) begin
                weCnt++;
                lastWd = bus.mem_wd;
                lastA  = bus.mem_a;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        if (bus.mem_we === 1'b1)
            weCnt++;
        sawErr = bus.err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL resetBusy: got %b expected 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL resetDone: got %b expected 0", bus.done); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("[TB] FAIL resetErr: got %b expected 0", bus.err); end
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("[TB] FAIL resetMemWe: got %b expected 0", bus.mem_we); end
        total++; if (bus.rdata !== 32'h0) begin bad++; $display("[TB] FAIL resetRdata: got %h expected 0", bus.rdata); end
        total++; if (bus.mem_a !== 32'h0) begin bad++; $display("[TB] FAIL resetMemA: got %h expected 0", bus.mem_a); end
        total++; if (bus.mem_wd !== 32'h0) begin bad++; $display("[TB] FAIL resetMemWd: got %h expected 0", bus.mem_wd); end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_loads;
        logic [1:0]  sizes [6] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b01};
        logic        sexts [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] addrs [6] = '{32'h11, 32'h12, 32'h13, 32'h12, 32'h10, 32'h10};
        logic [31:0] exps  [6] = '{32'hFFFFFFAA, 32'h00008899, 32'h00000088,
                                   32'hFFFF8899, 32'h8899AABB, 32'hFFFFAABB};
        int lat, weCnt;
        logic [31:0] wd, a;
        logic e;
        loadWord(6'd4, 32'h8899AABB);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, sizes[i], sexts[i], addrs[i], 32'h0, lat, weCnt, wd, a, e);
            total++; if (bus.rdata !== exps[i]) begin bad++; $display("[TB] FAIL loadData%0d: got %h expected %h", i, bus.rdata, exps[i]); end
            total++; if (lat !== 2) begin bad++; $display("[TB] FAIL loadLatency%0d: got %0d expected 2", i, lat); end
            total++; if (weCnt !== 0) begin bad++; $display("[TB] FAIL loadMemWe%0d: got %0d writes expected 0", i, weCnt); end
            total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL loadErr%0d: got %b expected 0", i, e); end
        end
    endtask

    task automatic test_byte_store;
        int lat, weCnt;
        logic [31:0] wd, a;
        logic e;
        loadWord(6'd4, 32'h8899AABB);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000005C, lat, weCnt, wd, a, e);
        total++; if (weCnt !== 1) begin bad++; $display("[TB] FAIL byteStoreWeCount: got %0d expected 1", weCnt); end
        total++; if (wd !== 32'h5C99AABB) begin bad++; $display("[TB] FAIL byteStoreMemWd: got %h expected 5c99aabb", wd); end
        total++; if (a !== 32'h10) begin bad++; $display("[TB] FAIL byteStoreMemA: got %h expected 00000010", a); end
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL byteStoreLatency: got %0d expected 3", lat); end
        total++; if (mem[4] !== 32'h5C99AABB) begin bad++; $display("[TB] FAIL byteStoreMem: got %h expected 5c99aabb", mem[4]); end
        total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL byteStoreErr: got %b expected 0", e); end
    endtask

    task automatic test_back_to_back;
        int lat, weCnt;
        bus.req       = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_sext  = 1'b0;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        lat   = 1;
        weCnt = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.mem_we === 1'b1) weCnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (bus.mem_we === 1'b1) weCnt++;
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL wordStoreLatency: got %0d expected 2", lat); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL respBusy: got %b expected 1", bus.busy); end
        bus.req_we   = 1'b0;
        bus.req_addr = 32'h20;
        @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL idleAfterDone: got busy=%b expected 0", bus.busy); end
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        lat     = 1;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.mem_we === 1'b1) weCnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        total++; if (weCnt !== 1) begin bad++; $display("[TB] FAIL heldReqWrites: got %0d expected 1", weCnt); end
        total++; if (mem[8] !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL wordStoreMem: got %h expected deadbeef", mem[8]); end
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL b2bLoadLatency: got %0d expected 2", lat); end
        total++; if (bus.rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL b2bLoadData: got %h expected deadbeef", bus.rdata); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_misaligned;
        int lat, weCnt;
        logic [31:0] wd, a;
        logic e;
        loadWord(6'd4, 32'h8899AABB);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, lat, weCnt, wd, a, e);
`ifdef MEM_MISALIGN_TRAP_EN
        total++; if (lat !== 1) begin bad++; $display("[TB] FAIL trapLatency: got %0d expected 1", lat); end
        total++; if (e !== 1'b1) begin bad++; $display("[TB] FAIL trapErr: got %b expected 1", e); end
        total++; if (bus.rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL trapRdata: got %h expected deadbeef", bus.rdata); end
`else
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL misHalfLatency: got %0d expected 2", lat); end
        total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL misHalfErr: got %b expected 0", e); end
        total++; if (bus.rdata !== 32'h0000AABB) begin bad++; $display("[TB] FAIL misHalfRdata: got %h expected 0000aabb", bus.rdata); end
`endif
        total++; if (bus.err !== 1'b0) begin bad++; $display("[TB] FAIL errOutsideDone: got %b expected 0", bus.err); end
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h22, 32'h12345678, lat, weCnt, wd, a, e);
`ifdef MEM_MISALIGN_TRAP_EN
        total++; if (weCnt !== 0) begin bad++; $display("[TB] FAIL trapStoreWrites: got %0d expected 0", weCnt); end
        total++; if (mem[8] !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL trapStoreMem: got %h expected deadbeef", mem[8]); end
        total++; if (e !== 1'b1) begin bad++; $display("[TB] FAIL trapStoreErr: got %b expected 1", e); end
`else
        total++; if (weCnt !== 1) begin bad++; $display("[TB] FAIL misWordWrites: got %0d expected 1", weCnt); end
        total++; if (mem[8] !== 32'h12345678) begin bad++; $display("[TB] FAIL misWordMem: got %h expected 12345678", mem[8]); end
        total++; if (a !== 32'h20) begin bad++; $display("[TB] FAIL misWordMemA: got %h expected 00000020", a); end
`endif
    endtask

    task automatic test_reset_mid;
        logic doneSeen;
        loadWord(6'd5, 32'h11223344);
        bus.req       = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'b01;
        bus.req_sext  = 1'b0;
        bus.req_addr  = 32'h16;
        bus.req_wdata = 32'h0000BEEF;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        @(posedge clk);
        #1;
        total++; if (bus.mem_we !== 1'b1) begin bad++; $display("[TB] FAIL halfStoreInWr: got mem_we=%b expected 1", bus.mem_we); end
        reset = 1'b1;
        #1;
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("[TB] FAIL resetMidMemWe: got %b expected 0", bus.mem_we); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL resetMidBusy: got %b expected 0", bus.busy); end
        @(posedge clk);
        #1;
        reset    = 1'b0;
        doneSeen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.done === 1'b1) doneSeen = 1'b1;
            @(posedge clk);
            #1;
        end
        total++; if (doneSeen !== 1'b0) begin bad++; $display("[TB] FAIL resetMidDone: got %b expected 0", doneSeen); end
        total++; if (mem[5] !== 32'h11223344) begin bad++; $display("[TB] FAIL resetMidMem: got %h expected 11223344", mem[5]); end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        tbWe          = 1'b0;
        tbIdx         = '0;
        tbData        = '0;
        bus.req       = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'b00;
        bus.req_sext  = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        reset         = 1'b1;
        #1;
        test_reset();
        test_loads();
        test_byte_store();
        test_back_to_back();
        test_misaligned();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
